// File: rtl/pic_priority_resolver.sv
// ----------------------------------------------------------------------------
// pic_priority_resolver
//
// Priority resolution stage of an 8259A-style interrupt controller. Holds the
// interrupt request register (IRR), the in-service register (ISR) and the
// rotating priority pointer (LP = lowest-priority level). It picks the next
// unmasked request to be serviced, presents it as INT/INT_VEC, and tracks the
// two INTA pulses of an acknowledge cycle plus the OCW2 EOI/rotate commands.
//
// Ports
//   CLK         in   system clock, all state on the rising edge
//   RESET       in   synchronous, active-high reset
//   IR[7:0]     in   interrupt request lines, already synchronous to CLK
//   IM[7:0]     in   interrupt mask, 1 = masked
//   LTIM        in   1 = level-triggered requests, 0 = edge-triggered
//   AEOI        in   1 = clear the serviced ISR bit at the end of the 2nd INTA
//   OCW2[7:0]   in   OCW2 byte, [7:5] = R,SL,EOI and [2:0] = level L
//   OCW2_WR     in   one-cycle strobe qualifying OCW2
//   first_ACK   in   high during the first INTA pulse
//   second_ACK  in   high during the second INTA pulse
//   INT         out  registered interrupt request to the CPU
//   INT_VEC     out  registered resolved level, frozen during acknowledge
//   IRR[7:0]    out  interrupt request register
//   ISR[7:0]    out  in-service register
//
// Acknowledge FSM
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | resolving; INT/INT_VEC track the current candidate
//   ACK1  | first INTA seen; level latched, INT low, waiting 2nd INTA
//   ACK2  | second INTA high; finishes (AEOI, rotation) when it falls
// ----------------------------------------------------------------------------
module pic_priority_resolver (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IR,
  input  logic [7:0] IM,
  input  logic       LTIM,
  input  logic       AEOI,
  input  logic [7:0] OCW2,
  input  logic       OCW2_WR,
  input  logic       first_ACK,
  input  logic       second_ACK,
  output logic       INT,
  output logic [2:0] INT_VEC,
  output logic [7:0] IRR,
  output logic [7:0] ISR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_t;

  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;
  localparam logic [2:0] OCW2_ROT_AEOI_S = 3'b100;
  localparam logic [2:0] OCW2_ROT_AEOI_C = 3'b000;

  state_t     state;
  state_t     state_next;

  logic [7:0] ir_q;
  logic       first_ack_q;
  logic       second_ack_q;
  logic [2:0] lp;
  logic       rot_aeoi;
  logic       spurious;

  // Returns {found, level} for the highest-priority set bit of vec. The
  // highest priority is lp+1, descending cyclically down to lp itself; the
  // loop walks from lowest to highest priority so the last hit wins.
  function automatic logic [3:0] pick_highest(input logic [7:0] vec,
                                              input logic [2:0] lp_i);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = lp_i + 3'(k) + 3'd1;
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Priority rank of a level: 0 = highest priority, 7 = lp itself.
  function automatic logic [2:0] rank_of(input logic [2:0] lvl,
                                         input logic [2:0] lp_i);
    return lvl - lp_i - 3'd1;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'b0000_0001 << lvl;
  endfunction

  // --------------------------------------------------------------------------
  // Resolution
  // --------------------------------------------------------------------------
  logic [3:0] irr_pick;
  logic [3:0] isr_pick;
  logic       cand_valid;
  logic [2:0] cand;

  assign irr_pick = pick_highest(IRR & ~IM, lp);
  assign isr_pick = pick_highest(ISR, lp);
  assign cand     = irr_pick[2:0];

  // Fully nested: a request only wins if it outranks every in-service level.
  assign cand_valid = irr_pick[3] &&
                      (!isr_pick[3] || (rank_of(irr_pick[2:0], lp) <
                                        rank_of(isr_pick[2:0], lp)));

  // --------------------------------------------------------------------------
  // INTA edge detection and FSM
  // --------------------------------------------------------------------------
  logic ack1_rise;
  logic ack2_rise;
  logic ack2_fall;
  logic ack_take;
  logic ack_done;

  assign ack1_rise = first_ACK & ~first_ack_q;
  assign ack2_rise = second_ACK & ~second_ack_q;
  assign ack2_fall = ~second_ACK & second_ack_q;
  assign ack_take  = (state == IDLE) && ack1_rise;
  assign ack_done  = (state == ACK2) && ack2_fall;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ack1_rise) state_next = ACK1;
      ACK1:    if (ack2_rise) state_next = ACK2;
      ACK2:    if (ack2_fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      first_ack_q  <= 1'b0;
      second_ack_q <= 1'b0;
      ir_q         <= 8'hFF;
    end else begin
      state        <= state_next;
      first_ack_q  <= first_ACK;
      second_ack_q <= second_ACK;
      ir_q         <= IR;
    end
  end

  // --------------------------------------------------------------------------
  // OCW2 decode
  // --------------------------------------------------------------------------
  logic [7:0] eoi_clr;
  logic       ocw_lp_wr;
  logic [2:0] ocw_lp;
  logic       rot_set;
  logic       rot_clr;

  logic       unused_ocw2_bits;
  assign unused_ocw2_bits = ^OCW2[4:3];

  always_comb begin
    eoi_clr   = 8'h00;
    ocw_lp_wr = 1'b0;
    ocw_lp    = 3'd0;
    rot_set   = 1'b0;
    rot_clr   = 1'b0;
    if (OCW2_WR) begin
      case (OCW2[7:5])
        OCW2_NS_EOI: begin
          if (isr_pick[3]) eoi_clr = onehot(isr_pick[2:0]);
        end
        OCW2_SP_EOI: begin
          eoi_clr = onehot(OCW2[2:0]);
        end
        OCW2_ROT_NS_EOI: begin
          // With nothing in service the whole command is a no-op, LP included.
          if (isr_pick[3]) begin
            eoi_clr   = onehot(isr_pick[2:0]);
            ocw_lp_wr = 1'b1;
            ocw_lp    = isr_pick[2:0];
          end
        end
        OCW2_ROT_SP_EOI: begin
          eoi_clr   = onehot(OCW2[2:0]);
          ocw_lp_wr = 1'b1;
          ocw_lp    = OCW2[2:0];
        end
        OCW2_SET_PRI: begin
          ocw_lp_wr = 1'b1;
          ocw_lp    = OCW2[2:0];
        end
        OCW2_ROT_AEOI_S: rot_set = 1'b1;
        OCW2_ROT_AEOI_C: rot_clr = 1'b1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // IRR / ISR next state
  // --------------------------------------------------------------------------
  logic [7:0] ack_set;
  logic [7:0] aeoi_clr;
  logic       aeoi_lp_wr;
  logic [7:0] edge_set;
  logic [7:0] irr_next;
  logic [7:0] isr_next;

  assign ack_set = (ack_take && cand_valid) ? onehot(cand) : 8'h00;

  // A spurious acknowledge put nothing in service, so it has nothing to
  // retire and no level to rotate to.
  assign aeoi_clr   = (ack_done && AEOI && !spurious) ? onehot(INT_VEC) : 8'h00;
  assign aeoi_lp_wr = ack_done && rot_aeoi && !spurious;

  // The fresh-edge term is not masked by the acknowledge, so a new rising
  // edge on the level being acknowledged keeps its request pending.
  assign edge_set = IR & ~ir_q;
  assign irr_next = LTIM ? (IR & ~ack_set)
                         : (edge_set | (IRR & IR & ~ack_set));

  // Set from the acknowledge dominates any clear of the same bit.
  assign isr_next = (ISR & ~eoi_clr & ~aeoi_clr) | ack_set;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IRR      <= 8'h00;
      ISR      <= 8'h00;
      lp       <= 3'd7;
      rot_aeoi <= 1'b0;
    end else begin
      IRR <= irr_next;
      ISR <= isr_next;
      // OCW2 priority change overrides an AEOI rotation in the same cycle.
      if (ocw_lp_wr)       lp <= ocw_lp;
      else if (aeoi_lp_wr) lp <= INT_VEC;
      if (rot_set)         rot_aeoi <= 1'b1;
      else if (rot_clr)    rot_aeoi <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // INT / INT_VEC
  // --------------------------------------------------------------------------
  // INT_VEC keeps its last value while there is no candidate and stays frozen
  // through ACK1/ACK2 so the control logic can read the serviced level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      INT      <= 1'b0;
      INT_VEC  <= 3'd0;
      spurious <= 1'b0;
    end else if (ack_take) begin
      INT      <= 1'b0;
      INT_VEC  <= cand_valid ? cand : 3'd7;
      spurious <= !cand_valid;
    end else if (state == IDLE) begin
      INT <= cand_valid;
      if (cand_valid) INT_VEC <= cand;
    end
  end

endmodule

// File: tb/tb_pic_priority_resolver.sv
module tb_pic_priority_resolver;

  logic       CLK;
  logic       RESET;
  logic [7:0] IR;
  logic [7:0] IM;
  logic       LTIM;
  logic       AEOI;
  logic [7:0] OCW2;
  logic       OCW2_WR;
  logic       first_ACK;
  logic       second_ACK;
  logic       INT;
  logic [2:0] INT_VEC;
  logic [7:0] IRR;
  logic [7:0] ISR;

  pic_priority_resolver dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IR         (IR),
    .IM         (IM),
    .LTIM       (LTIM),
    .AEOI       (AEOI),
    .OCW2       (OCW2),
    .OCW2_WR    (OCW2_WR),
    .first_ACK  (first_ACK),
    .second_ACK (second_ACK),
    .INT        (INT),
    .INT_VEC    (INT_VEC),
    .IRR        (IRR),
    .ISR        (ISR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {INT, INT_VEC, IRR, ISR} after each rising edge.
  logic [19:0] exp_q[$];

  // Reference model state.
  bit [7:0] m_irr, m_isr, m_irq;
  int       m_lp;
  bit       m_rot;
  int       m_phase;   // 0 idle, 1 after first INTA, 2 during second INTA
  bit       m_spur;
  bit       m_int;
  int       m_vec;
  bit       m_faq, m_saq;

  function automatic int hi_level(bit [7:0] v, int lp);
    for (int n = 1; n <= 8; n++)
      if (v[(lp + n) % 8]) return (lp + n) % 8;
    return -1;
  endfunction

  task automatic model_step();
    int       hi_isr, cand, lvl, cmd, l_fld;
    int       nx_phase, nx_vec, nx_lp;
    bit       nx_int, nx_spur, nx_rot;
    bit [7:0] eoi_clr, aeoi_clr, set_b, nx_irr;
    if (RESET) begin
      m_irr = 0; m_isr = 0; m_irq = 8'hFF; m_lp = 7; m_rot = 0;
      m_phase = 0; m_spur = 0; m_int = 0; m_vec = 0; m_faq = 0; m_saq = 0;
      return;
    end
    hi_isr = hi_level(m_isr, m_lp);
    cand = -1;
    for (int n = 1; n <= 8; n++) begin
      lvl = (m_lp + n) % 8;
      if (lvl == hi_isr) break;
      if (m_irr[lvl] && !IM[lvl]) begin
        cand = lvl;
        break;
      end
    end
    nx_phase = m_phase; nx_vec = m_vec; nx_int = m_int; nx_spur = m_spur;
    nx_lp = m_lp; nx_rot = m_rot;
    eoi_clr = 0; aeoi_clr = 0; set_b = 0;
    if (m_phase == 0) begin
      if (first_ACK && !m_faq) begin
        nx_phase = 1;
        nx_int   = 0;
        if (cand >= 0) begin
          set_b[cand] = 1; nx_vec = cand; nx_spur = 0;
        end else begin
          nx_vec = 7; nx_spur = 1;
        end
      end else begin
        nx_int = (cand >= 0);
        if (cand >= 0) nx_vec = cand;
      end
    end else if (m_phase == 1) begin
      if (second_ACK && !m_saq) nx_phase = 2;
    end else begin
      if (!second_ACK && m_saq) begin
        nx_phase = 0;
        if (AEOI && !m_spur) aeoi_clr[m_vec] = 1;
        if (m_rot && !m_spur) nx_lp = m_vec;
      end
    end
    if (OCW2_WR) begin
      cmd   = int'(OCW2[7:5]);
      l_fld = int'(OCW2[2:0]);
      case (cmd)
        1: if (hi_isr >= 0) eoi_clr[hi_isr] = 1;
        3: eoi_clr[l_fld] = 1;
        5: if (hi_isr >= 0) begin eoi_clr[hi_isr] = 1; nx_lp = hi_isr; end
        7: begin eoi_clr[l_fld] = 1; nx_lp = l_fld; end
        6: nx_lp = l_fld;
        4: nx_rot = 1;
        0: nx_rot = 0;
        default: ;
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      if (LTIM) nx_irr[i] = IR[i] && !set_b[i];
      else      nx_irr[i] = (IR[i] && !m_irq[i]) || (m_irr[i] && IR[i] && !set_b[i]);
    end
    m_isr = (m_isr & ~eoi_clr & ~aeoi_clr) | set_b;
    m_irr = nx_irr; m_irq = IR; m_faq = first_ACK; m_saq = second_ACK;
    m_phase = nx_phase; m_vec = nx_vec; m_int = nx_int; m_spur = nx_spur;
    m_lp = nx_lp; m_rot = nx_rot;
  endtask

  // Inputs are set at the falling edge; the model advances and its prediction
  // for the following rising edge is queued for the monitor.
  task automatic tick();
    model_step();
    exp_q.push_back({m_int, 3'(m_vec), m_irr, m_isr});
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic inta();
    first_ACK = 1; ticks(2);
    first_ACK = 0; tick();
    second_ACK = 1; ticks(2);
    second_ACK = 0; ticks(2);
  endtask

  task automatic ocw(input logic [7:0] b);
    OCW2 = b; OCW2_WR = 1; tick();
    OCW2_WR = 0; OCW2 = 8'h00;
  endtask

  // Monitor: every rising edge presents a new output state.
  initial begin
    logic [19:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({INT, INT_VEC, IRR, ISR} !== e) begin
          n_fail++;
          $display("FAIL cycle t=%0t: got INT=%0b VEC=%0d IRR=%h ISR=%h, expected INT=%0b VEC=%0d IRR=%h ISR=%h",
                   $time, INT, INT_VEC, IRR, ISR, e[19], e[18:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int inta_step;

  initial begin
    RESET = 1; IR = 0; IM = 0; LTIM = 0; AEOI = 0; OCW2 = 0; OCW2_WR = 0;
    first_ACK = 0; second_ACK = 0;
    ticks(3);
    chk("reset_int", {7'd0, INT}, 8'h00);
    chk("reset_irr", IRR, 8'h00);
    RESET = 0; ticks(2);

    // 1: edge mode, LP=7
    IR = 8'h24; ticks(3);
    chk("t1_int", {7'd0, INT}, 8'h01);
    chk("t1_vec", {5'd0, INT_VEC}, 8'd2);
    inta();
    chk("t1_isr", ISR, 8'h04);
    chk("t1_irr", IRR, 8'h20);
    chk("t1_nested_int", {7'd0, INT}, 8'h00);

    // 2: non-specific EOI
    ocw(8'h20); ticks(2);
    chk("t2_isr", ISR, 8'h00);
    chk("t2_vec", {5'd0, INT_VEC}, 8'd5);

    // 3: set priority L=3
    ocw(8'hC3);
    IR = 8'h00; ticks(2);
    IR = 8'h11; ticks(3);
    chk("t3_vec", {5'd0, INT_VEC}, 8'd4);

    // 4: AEOI with rotation
    AEOI = 1; ocw(8'h80);
    IR = 8'h00; ticks(2);
    IR = 8'h40; ticks(3);
    chk("t4_vec6", {5'd0, INT_VEC}, 8'd6);
    inta();
    chk("t4_isr", ISR, 8'h00);
    IR = 8'h00; ticks(2);
    IR = 8'h81; ticks(3);
    chk("t4_vec7", {5'd0, INT_VEC}, 8'd7);

    // 5: withdrawn request then spurious ack, reset mid-acknowledge
    AEOI = 0; IR = 8'h00; ticks(3);
    IR = 8'h08; tick();
    IR = 8'h00; ticks(2);
    first_ACK = 1; tick();
    chk("t5_spur_vec", {5'd0, INT_VEC}, 8'd7);
    chk("t5_spur_isr", ISR, 8'h00);
    RESET = 1; first_ACK = 0; ticks(2);
    chk("t5_rst_int", {7'd0, INT}, 8'h00);
    chk("t5_rst_vec", {5'd0, INT_VEC}, 8'd0);
    RESET = 0; tick();
    IR = 8'h81; ticks(3);
    chk("t5_lp7_vec", {5'd0, INT_VEC}, 8'd0);

    // 6: level mode with mask
    LTIM = 1; IM = 8'h02; IR = 8'h02; ticks(3);
    chk("t6_masked_int", {7'd0, INT}, 8'h00);
    IM = 8'h00; ticks(2);
    chk("t6_int", {7'd0, INT}, 8'h01);
    chk("t6_vec", {5'd0, INT_VEC}, 8'd1);
    LTIM = 0; IR = 8'h00; ticks(2);

    // Randomized phase against the reference model
    inta_step = 0;
    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(499) == 0);
      if ($urandom_range(5) == 0) IR = IR ^ (8'h01 << $urandom_range(7));
      if ($urandom_range(63) == 0) IM = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(199) == 0) LTIM = ~LTIM;
      if ($urandom_range(99) == 0) AEOI = 1'($urandom);
      OCW2_WR = ($urandom_range(19) == 0);
      OCW2 = OCW2_WR ? 8'($urandom) : 8'h00;
      if (inta_step == 0 && $urandom_range(9) == 0) inta_step = 1;
      if (inta_step != 0) begin
        first_ACK  = (inta_step == 1 || inta_step == 2) ||
                     (inta_step == 5 && $urandom_range(3) == 0);
        second_ACK = (inta_step == 4 || inta_step == 5);
        inta_step  = (inta_step == 7) ? 0 : inta_step + 1;
      end else begin
        first_ACK = 0; second_ACK = 0;
      end
      tick();
    end
    RESET = 0; OCW2_WR = 0; first_ACK = 0; second_ACK = 0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
